// File: rtl/counter_timer_ctrl_if.sv
// counter_timer_ctrl_if
//   Control/status bundle between a host sequencer and counter_timer_ctrl.
//
//   Signalling: there is no valid/ready pair. start, stop and hold are
//   levels sampled on every rising clock edge, and limit is sampled together
//   with an accepted start (or an auto-reload). The status outputs q, busy,
//   done and state are registered and valid in every cycle.
//
//   Ports (master = host side, slave = timer side):
//     start  host->timer  1      begin a run (accepted in IDLE and DONE)
//     stop   host->timer  1      abort the run, return to IDLE
//     hold   host->timer  1      freeze counting while high during a run
//     limit  host->timer  WIDTH  terminal count for the next run
//     q      timer->host  WIDTH  current count
//     busy   timer->host  1      high in RUN or PAUSE
//     done   timer->host  1      one-cycle completion pulse
//     state  timer->host  2      IDLE=00 RUN=01 PAUSE=10 DONE=11
interface counter_timer_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic             hold;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
   logic [1:0]       state;

   modport master (
      output start, stop, hold, limit,
      input  q, busy, done, state
   );

   modport slave (
      input  start, stop, hold, limit,
      output q, busy, done, state
   );
endinterface

// File: rtl/counter_timer_ctrl.sv
// counter_timer_ctrl
//   Start/stop programmable interval timer around a WIDTH-bit up-counter,
//   with hold, terminal-count detection and a one-cycle completion pulse.
//
//   Optional feature macro: AUTO_RELOAD_EN
//     defined   : DONE with no start/stop reloads limit and runs again
//                 (periodic timer, period limit+2 cycles)
//     undefined : DONE with no start/stop returns to IDLE, q keeps limit
//
//   Ports:
//     clk  in   rising-edge clock
//     clr  in   asynchronous active-low reset
//     bus  slave modport of counter_timer_ctrl_if (start/stop/hold/limit
//          in; q/busy/done/state out, all registered)
//
//   Priority at every edge: clr > stop > start (IDLE/DONE only) > hold >
//   terminal count > increment.
module counter_timer_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  clr,
   counter_timer_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nxt;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] limit_r;
   logic [WIDTH-1:0] limit_nxt;
   logic             busy_r;
   logic             done_r;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_r <= S_IDLE;
         q_r     <= '0;
         limit_r <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt;
         q_r     <= q_nxt;
         limit_r <= limit_nxt;
         // Flags are decoded from the next state so they change on the same
         // edge as state and still come straight out of flops.
         busy_r  <= (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
         done_r  <= (state_nxt == S_DONE);
      end
   end

   always_comb begin
      state_nxt = state_r;
      q_nxt     = q_r;
      limit_nxt = limit_r;
      unique case (state_r)
         S_IDLE: begin
            if (bus.stop) begin
               q_nxt = '0;
            end else if (bus.start) begin
               state_nxt = S_RUN;
               q_nxt     = '0;
               limit_nxt = bus.limit;
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               state_nxt = S_IDLE;
               q_nxt     = '0;
            end else if (bus.hold) begin
               state_nxt = S_PAUSE;
            end else if (q_r == limit_r) begin
               // Terminal test before increment keeps q from wrapping.
               state_nxt = S_DONE;
            end else begin
               q_nxt = q_r + ONE;
            end
         end
         S_PAUSE: begin
            if (bus.stop) begin
               state_nxt = S_IDLE;
               q_nxt     = '0;
            end else if (!bus.hold) begin
               // Resume edge only changes state; counting restarts next edge.
               state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            if (bus.stop) begin
               state_nxt = S_IDLE;
               q_nxt     = '0;
            end else if (bus.start) begin
               state_nxt = S_RUN;
               q_nxt     = '0;
               limit_nxt = bus.limit;
            end else begin
`ifdef AUTO_RELOAD_EN
               state_nxt = S_RUN;
               q_nxt     = '0;
               limit_nxt = bus.limit;
`else
               // One-shot: q already equals limit_r and simply holds.
               state_nxt = S_IDLE;
`endif
            end
         end
         default: begin
            state_nxt = S_IDLE;
            q_nxt     = '0;
         end
      endcase
   end

   assign bus.q     = q_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.state = state_r;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// tb_counter_timer_ctrl
//   Scoreboard bench for counter_timer_ctrl. The driver applies one input
//   vector per cycle on the falling edge, advances a behavioural timer model
//   and pushes the expected post-edge outputs into exp_q. The monitor pops
//   one entry per rising edge and compares. Packed entry: {state,busy,done,q}.
//   Honours AUTO_RELOAD_EN the same way the design does.
module tb_counter_timer_ctrl;

   localparam int W = 4;

   logic clk;
   logic clr;

   counter_timer_ctrl_if #(.WIDTH(W)) bus ();

   counter_timer_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int         n_vec  = 0;
   int         n_miss = 0;
   bit         drv_done = 0;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got state=%b busy=%b done=%b q=%0d, expected state=%b busy=%b done=%b q=%0d",
                  name, $time, got[7:6], got[5], got[4], got[3:0],
                  exp[7:6], exp[5], exp[4], exp[3:0]);
      end
   endtask

   function automatic logic [7:0] dut_out();
      return {bus.state, bus.busy, bus.done, bus.q};
   endfunction

   // ---------------- reference model ----------------
   // A run is "in_run" from its start until completion or abort; "frozen"
   // marks the held part of a run; "pulse" is the single completion cycle.
   bit         in_run, frozen, pulse;
   int         count, term;

   function automatic void model_reset();
      in_run = 0; frozen = 0; pulse = 0; count = 0; term = 0;
   endfunction

   function automatic void begin_run(input int lim);
      in_run = 1; frozen = 0; pulse = 0; count = 0; term = lim;
   endfunction

   function automatic void model_step(input bit st, input bit sp, input bit hd, input int lim);
      if (sp) begin
         // Abort from anywhere: counter cleared, timer idle.
         in_run = 0; frozen = 0; pulse = 0; count = 0;
      end else if (pulse) begin
         pulse = 0;
         if (st) begin_run(lim);
`ifdef AUTO_RELOAD_EN
         else begin_run(lim);
`endif
      end else if (in_run) begin
         if (frozen) frozen = hd;            // resume costs one edge
         else if (hd) frozen = 1;
         else if (count == term) begin in_run = 0; pulse = 1; end
         else count = count + 1;
      end else if (st) begin
         begin_run(lim);
      end
   endfunction

   function automatic logic [7:0] model_out();
      logic [1:0] s;
      logic [3:0] qv;
      if (pulse) s = 2'b11;
      else if (in_run) s = frozen ? 2'b10 : 2'b01;
      else s = 2'b00;
      qv = 4'(count);
      return {s, in_run, pulse, qv};
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input bit c, input bit st, input bit sp, input bit hd, input int lim);
      @(negedge clk);
      clr       = c;
      bus.start = st;
      bus.stop  = sp;
      bus.hold  = hd;
      bus.limit = 4'(lim);
      if (!c) model_reset();
      else model_step(st, sp, hd, lim);
      exp_q.push_back(model_out());
   endtask

   task automatic idle_cycles(input int n, input int lim);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, lim);
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) check("cycle", dut_out(), exp_q.pop_front());
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      clr       = 1'b0;
      bus.start = 1'b1;
      bus.stop  = 1'b0;
      bus.hold  = 1'b0;
      bus.limit = 4'd7;
      #2;
      check("reset_before_edge", dut_out(), 8'h00);

      // Reset held low with start high, then release with no start.
      drive(0, 1, 0, 0, 7);
      drive(0, 1, 0, 0, 7);
      idle_cycles(3, 7);

      // One-shot, limit 5; limit wiggles mid-run and must be ignored.
      drive(1, 1, 0, 0, 5);
      for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, (i * 3) & 15);

      // Hold for two cycles while q=1, limit 3.
      drive(1, 1, 0, 0, 3);
      drive(1, 0, 0, 0, 3);
      drive(1, 0, 0, 1, 3);
      drive(1, 0, 0, 1, 3);
      idle_cycles(7, 3);

      // Abort at q=2, then start+stop together in IDLE.
      drive(1, 1, 0, 0, 9);
      idle_cycles(2, 9);
      drive(1, 0, 1, 0, 9);
      drive(1, 1, 1, 0, 9);
      idle_cycles(2, 9);

      // limit 0 and limit 15.
      drive(1, 1, 0, 0, 0);
      idle_cycles(3, 0);
      drive(1, 1, 0, 0, 15);
      idle_cycles(18, 15);

      // Restart during the DONE cycle.
      drive(1, 1, 0, 0, 2);
      idle_cycles(3, 2);
      drive(1, 1, 0, 0, 1);
      idle_cycles(5, 1);

      // Periodic check with limit 2 (one-shot build just goes idle).
      drive(1, 1, 0, 0, 2);
      idle_cycles(13, 2);

      // Asynchronous clear mid-period, away from any clock edge.
      @(posedge clk);
      #3;
      clr = 1'b0;
      model_reset();
      #1;
      check("async_clear", dut_out(), 8'h00);
      drive(0, 1, 0, 0, 4);
      idle_cycles(3, 4);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         drive(1,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 24) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 15));
      end
      idle_cycles(20, 0);
      drive(1, 0, 1, 0, 0);
      drv_done = 1;
   end

   // ---------------- final report ----------------
   initial begin
      wait (drv_done);
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
